// File: rtl/mul_pkg.sv
// Shared encodings for the iterative LEGv8 multiplier: opcodes, FSM states and
// the zero-register index that must never be written.
package mul_pkg;

   typedef enum logic [1:0] {
      OP_MUL   = 2'b00,
      OP_UMULH = 2'b01,
      OP_SMULH = 2'b10,
      OP_RSVD  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_FIX,
      S_DONE
   } state_e;

   localparam logic [4:0] XZR_IDX = 5'd31;

endpackage

// File: rtl/mul_datapath.sv
// Shift-add datapath: unsigned magnitude multiply with a final sign fix-up and
// half selection into the result register.
module mul_datapath #(
   parameter int WIDTH = 64
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             i_load,
   input  logic             i_step,
   input  logic             i_fix,
   input  logic             i_signed,
   input  logic             i_sel_hi,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH-1:0] o_result
);

   logic [2*WIDTH-1:0] r_acc;
   logic [WIDTH-1:0]   r_mcand;
   logic [WIDTH-1:0]   r_mplier;
   logic [WIDTH-1:0]   r_result;
   logic               r_neg;

   logic [WIDTH-1:0]   w_abs_a;
   logic [WIDTH-1:0]   w_abs_b;
   logic [WIDTH-1:0]   w_addend;
   logic [WIDTH:0]     w_sum;
   logic [2*WIDTH-1:0] w_fixed;

   // Magnitudes are unsigned, so the most negative input maps cleanly to 2^(WIDTH-1).
   assign w_abs_a  = (i_signed && i_a[WIDTH-1]) ? -i_a : i_a;
   assign w_abs_b  = (i_signed && i_b[WIDTH-1]) ? -i_b : i_b;
   assign w_addend = r_mplier[0] ? r_mcand : '0;
   assign w_sum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
   assign w_fixed  = r_neg ? -r_acc : r_acc;
   assign o_result = r_result;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_result <= '0;
         r_neg    <= 1'b0;
      end else if (i_load) begin
         r_acc    <= '0;
         r_mcand  <= w_abs_a;
         r_mplier <= w_abs_b;
         r_neg    <= i_signed & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
      end else if (i_step) begin
         // Carry out of the upper-half add becomes the new MSB after the shift.
         r_acc    <= {w_sum, r_acc[WIDTH-1:1]};
         r_mplier <= r_mplier >> 1;
      end else if (i_fix) begin
         r_acc    <= w_fixed;
         r_result <= i_sel_hi ? w_fixed[2*WIDTH-1:WIDTH] : w_fixed[WIDTH-1:0];
      end
   end

endmodule

// File: rtl/mul_unit.sv
// Iterative 64x64 multiplier for MUL/UMULH/SMULH; control FSM and iteration
// counter, with outputs shaped for the register file's negedge write port.
module mul_unit
   import mul_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int CNT_W = 7
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic [4:0]       dest_add,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             write_en,
   output logic [4:0]       write_add
);

   state_e           r_state;
   state_e           w_next;
   logic [CNT_W-1:0] r_count;
   op_e              r_op;
   logic [4:0]       r_dest;

   logic             w_load;
   logic             w_step;
   logic             w_fix;
   logic             w_signed;
   logic             w_sel_hi;

   assign w_signed  = (op_e'(op) == OP_SMULH);
   assign w_sel_hi  = (r_op == OP_UMULH) || (r_op == OP_SMULH);

   assign busy      = (r_state != S_IDLE);
   assign done      = (r_state == S_DONE);
   assign write_en  = done && (r_dest != XZR_IDX);
   assign write_add = r_dest;

   always_comb begin
      w_next = r_state;
      w_load = 1'b0;
      w_step = 1'b0;
      w_fix  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_load = 1'b1;
               w_next = S_RUN;
            end
         end
         S_RUN: begin
            w_step = 1'b1;
            if (r_count == CNT_W'(WIDTH - 1)) begin
               w_next = S_FIX;
            end
         end
         S_FIX: begin
            w_fix  = 1'b1;
            w_next = S_DONE;
         end
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_count <= '0;
         r_op    <= OP_MUL;
         r_dest  <= '0;
      end else begin
         r_state <= w_next;
         if (w_load) begin
            r_count <= '0;
            r_op    <= op_e'(op);
            r_dest  <= dest_add;
         end else if (w_step) begin
            r_count <= r_count + CNT_W'(1);
         end
      end
   end

   mul_datapath #(
      .WIDTH (WIDTH)
   ) u_datapath (
      .clock    (clock),
      .reset_n  (reset_n),
      .i_load   (w_load),
      .i_step   (w_step),
      .i_fix    (w_fix),
      .i_signed (w_signed),
      .i_sel_hi (w_sel_hi),
      .i_a      (op_a),
      .i_b      (op_b),
      .o_result (result)
   );

endmodule

// File: tb/tb_mul_unit.sv
// Scoreboard bench for mul_unit: directed operations push expected write-port
// responses; a negedge monitor checks every done pulse against the queue.
module tb_mul_unit;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [63:0] op_a = '0;
   logic [63:0] op_b = '0;
   logic [4:0]  dest_add = '0;
   logic        busy;
   logic        done;
   logic [63:0] result;
   logic        write_en;
   logic [4:0]  write_add;

   typedef struct {
      logic [63:0] res;
      logic        we;
      logic [4:0]  add;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;

   mul_unit #(
      .WIDTH (64),
      .CNT_W (7)
   ) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .start     (start),
      .op        (op),
      .op_a      (op_a),
      .op_b      (op_b),
      .dest_add  (dest_add),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .write_en  (write_en),
      .write_add (write_add)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h (cyc=%0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clock) begin
      if (reset_n && done) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done actual=done@%0d result=%h expected=no_done", cyc, result);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("result", result, e.res);
            chk("write_en", 64'(write_en), 64'(e.we));
            chk("write_add", 64'(write_add), 64'(e.add));
            chk("done_cycle", 64'(cyc), 64'(e.cyc));
         end
      end
   end

   task automatic issue(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b,
                        input logic [4:0] d, input logic [63:0] exp_res, input bit push,
                        output int c0);
      exp_t e;
      @(negedge clock);
      op = o; op_a = a; op_b = b; dest_add = d; start = 1'b1;
      c0 = cyc;
      if (push) begin
         e.res = exp_res; e.we = (d != 5'd31); e.add = d; e.cyc = c0 + 66;
         sb.push_back(e);
      end
      @(posedge clock);
      #1;
      start = 1'b0;
      op_a = {$urandom, $urandom};
      op_b = {$urandom, $urandom};
      dest_add = 5'($urandom);
      op = 2'($urandom);
   endtask

   task automatic wait_cyc(input int target);
      int n = 0;
      while (cyc < target && n < 400) begin
         @(negedge clock);
         n++;
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((sb.size() != 0 || busy) && n < 400) begin
         @(negedge clock);
         n++;
      end
      checks++;
      if (n >= 400) begin
         failures++;
         $display("FAIL wait_idle actual=timeout pending=%0d expected=drained", sb.size());
         sb.delete();
      end
   endtask

   initial begin
      int c0;
      exp_t e;

      #1;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_result", result, 64'd0);
      chk("rst_write_en", 64'(write_en), 64'd0);
      chk("rst_write_add", 64'(write_add), 64'd0);
      repeat (3) @(negedge clock);
      reset_n = 1'b1;

      // MUL 3x5 with busy window checks
      issue(2'b00, 64'd3, 64'd5, 5'd7, 64'd15, 1'b1, c0);
      chk("busy_after_accept", 64'(busy), 64'd1);
      wait_cyc(c0 + 66);
      chk("busy_in_done", 64'(busy), 64'd1);
      wait_cyc(c0 + 67);
      chk("busy_after_done", 64'(busy), 64'd0);
      wait_idle();

      issue(2'b01, '1, '1, 5'd1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, c0);
      wait_idle();
      issue(2'b00, '1, '1, 5'd2, 64'h0000_0000_0000_0001, 1'b1, c0);
      wait_idle();
      issue(2'b10, '1, 64'd1, 5'd3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, c0);
      wait_idle();
      issue(2'b10, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'd4,
            64'h4000_0000_0000_0000, 1'b1, c0);
      wait_idle();
      // -2 * 3 = -6: upper half is all ones
      issue(2'b10, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 5'd6, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, c0);
      wait_idle();
      // 2^63 * 4 unsigned: upper half is 2
      issue(2'b01, 64'h8000_0000_0000_0000, 64'd4, 5'd8, 64'd2, 1'b1, c0);
      wait_idle();
      issue(2'b11, 64'd3, 64'd5, 5'd10, 64'd15, 1'b1, c0);
      wait_idle();
      issue(2'b00, 64'd2, 64'd2, 5'd31, 64'd4, 1'b1, c0);
      wait_idle();

      // start pulsed during RUN must be ignored
      issue(2'b00, 64'd100, 64'd200, 5'd5, 64'd20000, 1'b1, c0);
      wait_cyc(c0 + 10);
      op = 2'b00; op_a = 64'd9; op_b = 64'd9; dest_add = 5'd12; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      wait_idle();
      repeat (80) @(negedge clock);

      // start held high: accepts 67 cycles apart
      @(negedge clock);
      op = 2'b00; op_a = 64'd6; op_b = 64'd7; dest_add = 5'd3; start = 1'b1;
      c0 = cyc;
      e.res = 64'd42;  e.we = 1'b1; e.add = 5'd3; e.cyc = c0 + 66;  sb.push_back(e);
      e.res = 64'd110; e.we = 1'b1; e.add = 5'd4; e.cyc = c0 + 133; sb.push_back(e);
      @(posedge clock);
      #1;
      op_a = 64'd10; op_b = 64'd11; dest_add = 5'd4;
      wait_cyc(c0 + 68);
      start = 1'b0;
      wait_idle();

      // Reset mid-RUN aborts with no done or write
      issue(2'b00, 64'd11, 64'd13, 5'd14, 64'd143, 1'b0, c0);
      wait_cyc(c0 + 31);
      reset_n = 1'b0;
      #1;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_done", 64'(done), 64'd0);
      chk("abort_result", result, 64'd0);
      chk("abort_write_en", 64'(write_en), 64'd0);
      chk("abort_write_add", 64'(write_add), 64'd0);
      repeat (3) @(negedge clock);
      reset_n = 1'b1;
      repeat (100) @(negedge clock);
      chk("abort_stays_idle", 64'(busy), 64'd0);
      issue(2'b00, 64'd6, 64'd7, 5'd9, 64'd42, 1'b1, c0);
      wait_idle();

      repeat (150) @(negedge clock);
      chk("scoreboard_empty", 64'(sb.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
